// File: rtl/conv_pkg.sv
// Shared types and helpers for the per-layer convolution controllers in the chain.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    OUT     = 2'd3
  } conv_state_t;

  // Address width for a memory of n entries; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_ctrl_counter.sv
// Synchronous mod-(MAX+1) counter with clear priority; last flags the terminal count.
module conv_ctrl_counter #(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = (cnt_q == W'(MAX));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_layer_ctrl.sv
// Control FSM for one 1-D convolution layer: loads N inputs, then runs N-M+1
// M-tap MAC windows, presenting each result on a valid/ready output handshake.
module conv_layer_ctrl
  import conv_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned M  = 4,
  localparam int unsigned XW = addr_w(N),
  localparam int unsigned FW = addr_w(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          x_wr_en,
  output logic [XW-1:0] x_wr_addr,
  output logic [XW-1:0] x_rd_addr,
  output logic [FW-1:0] f_addr,
  output logic          mac_en,
  output logic          mac_first,
  output logic          m_valid,
  input  logic          m_ready
);

  if (N < 1 || M < 1 || M > N) begin : g_param_err
    $error("conv_layer_ctrl: requires 1 <= M <= N");
  end

  conv_state_t   state_q;
  conv_state_t   state_d;

  logic          w_inc;
  logic          j_inc;
  logic          j_clr;
  logic          k_inc;
  logic          k_clr;
  logic [XW-1:0] wcnt;
  logic [XW-1:0] j_cnt;
  logic [FW-1:0] k_cnt;
  logic          w_last;
  logic          j_last;
  logic          k_last;
  logic          mac_en_q;
  logic          mac_first_q;

  // Write pointer, window start and tap index.
  conv_ctrl_counter #(.MAX(N - 1), .W(XW)) u_wcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (w_inc),
    .cnt   (wcnt),
    .last  (w_last)
  );

  conv_ctrl_counter #(.MAX(N - M), .W(XW)) u_jcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (j_clr),
    .inc   (j_inc),
    .cnt   (j_cnt),
    .last  (j_last)
  );

  conv_ctrl_counter #(.MAX(M - 1), .W(FW)) u_kcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (k_clr),
    .inc   (k_inc),
    .cnt   (k_cnt),
    .last  (k_last)
  );

  // Outputs are decodes of state/counters or flops; x_wr_en is the write strobe.
  assign s_ready   = (state_q == LOAD);
  assign m_valid   = (state_q == OUT);
  assign x_wr_en   = s_valid & s_ready;
  assign x_wr_addr = wcnt;
  assign x_rd_addr = j_cnt + XW'(k_cnt);
  assign f_addr    = k_cnt;
  assign mac_en    = mac_en_q;
  assign mac_first = mac_first_q;

  always_comb begin
    state_d = state_q;
    w_inc   = 1'b0;
    j_inc   = 1'b0;
    j_clr   = 1'b0;
    k_inc   = 1'b0;
    k_clr   = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_valid) begin
          w_inc = 1'b1;
          if (w_last) begin
            j_clr   = 1'b1;
            k_clr   = 1'b1;
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        k_inc = 1'b1;
        if (k_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        if (m_ready) begin
          j_inc   = 1'b1;
          state_d = j_last ? LOAD : COMPUTE;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // MAC strobes trail the read addresses by one cycle to meet the read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mac_en_q    <= (state_q == COMPUTE);
      mac_first_q <= (state_q == COMPUTE) && (k_cnt == '0);
    end
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: drives an N=8/M=4 and an N=3/M=2 instance, models
// x-mem, f_rom and MAC around them, and compares results to direct dot products.
module tb_conv_layer_ctrl;

  logic clk;
  logic reset;
  logic s_valid;
  logic m_ready;
  logic sel;
  int   s_data;

  logic       a_s_ready, a_x_wr_en, a_mac_en, a_mac_first, a_m_valid;
  logic [2:0] a_x_wr_addr, a_x_rd_addr;
  logic [1:0] a_f_addr;
  logic       b_s_ready, b_x_wr_en, b_mac_en, b_mac_first, b_m_valid;
  logic [1:0] b_x_wr_addr, b_x_rd_addr;
  logic [0:0] b_f_addr;
  logic       a_s_valid, a_m_ready, b_s_valid, b_m_ready;

  int o_sr, o_wr_en, o_wr_addr, o_rd, o_f, o_mac_en, o_first, o_mv;
  int cn, cm;
  int from [4];
  int gx [8];
  int xmem [8];
  int x_q, f_q, acc;
  int n_vec, n_err;

  assign a_s_valid = s_valid & ~sel;
  assign a_m_ready = m_ready & ~sel;
  assign b_s_valid = s_valid & sel;
  assign b_m_ready = m_ready & sel;

  conv_layer_ctrl #(.N(8), .M(4)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (a_s_valid),
    .s_ready   (a_s_ready),
    .x_wr_en   (a_x_wr_en),
    .x_wr_addr (a_x_wr_addr),
    .x_rd_addr (a_x_rd_addr),
    .f_addr    (a_f_addr),
    .mac_en    (a_mac_en),
    .mac_first (a_mac_first),
    .m_valid   (a_m_valid),
    .m_ready   (a_m_ready)
  );

  conv_layer_ctrl #(.N(3), .M(2)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (b_s_valid),
    .s_ready   (b_s_ready),
    .x_wr_en   (b_x_wr_en),
    .x_wr_addr (b_x_wr_addr),
    .x_rd_addr (b_x_rd_addr),
    .f_addr    (b_f_addr),
    .mac_en    (b_mac_en),
    .mac_first (b_mac_first),
    .m_valid   (b_m_valid),
    .m_ready   (b_m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (!sel) begin
      o_sr      = int'(a_s_ready);
      o_wr_en   = int'(a_x_wr_en);
      o_wr_addr = int'(a_x_wr_addr);
      o_rd      = int'(a_x_rd_addr);
      o_f       = int'(a_f_addr);
      o_mac_en  = int'(a_mac_en);
      o_first   = int'(a_mac_first);
      o_mv      = int'(a_m_valid);
    end else begin
      o_sr      = int'(b_s_ready);
      o_wr_en   = int'(b_x_wr_en);
      o_wr_addr = int'(b_x_wr_addr);
      o_rd      = int'(b_x_rd_addr);
      o_f       = int'(b_f_addr);
      o_mac_en  = int'(b_mac_en);
      o_first   = int'(b_mac_first);
      o_mv      = int'(b_m_valid);
    end
  end

  // Datapath around the controller: x-mem, f_rom with 1-cycle reads, accumulator.
  always @(posedge clk) begin
    if (o_wr_en != 0) xmem[o_wr_addr] <= s_data;
    x_q <= xmem[o_rd];
    f_q <= from[o_f];
    if (o_mac_en != 0) acc <= (o_first != 0) ? x_q * f_q : acc + x_q * f_q;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int golden(input int j);
    int y = 0;
    for (int k = 0; k < cm; k++) y += gx[j + k] * from[k];
    return y;
  endfunction

  task automatic load_vec(input bit toggle, input bit ramp);
    int  i = 0;
    int  cyc = 0;
    int  d;
    bit  v;
    while (i < cn && cyc < 4 * cn + 8) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      d = ramp ? i + 1 : int'($urandom_range(15)) - 8;
      s_valid = v;
      s_data  = d;
      m_ready = 1'($urandom_range(1));
      #1;
      check_eq("s_ready_load", o_sr, 1);
      check_eq("m_valid_load", o_mv, 0);
      check_eq("x_wr_en", o_wr_en, int'(v));
      if (v) check_eq("x_wr_addr", o_wr_addr, i);
      step();
      if (v) begin
        gx[i] = d;
        i++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check_eq("load_count", i, cn);
    check_eq("s_ready_after_load", o_sr, 0);
  endtask

  // Entered on the first COMPUTE cycle of window j; leaves after the output handshake.
  task automatic compute_out(input int j, input int hold);
    int acc_seen;
    for (int c = 0; c <= cm; c++) begin
      s_valid = 1'($urandom_range(1));
      m_ready = 1'($urandom_range(1));
      #1;
      if (c < cm) begin
        check_eq("x_rd_addr", o_rd, j + c);
        check_eq("f_addr", o_f, c);
      end
      check_eq("mac_en", o_mac_en, int'(c >= 1));
      check_eq("mac_first", o_first, int'(c == 1));
      check_eq("m_valid_early", o_mv, 0);
      check_eq("s_ready_busy", o_sr, 0);
      check_eq("x_wr_en_busy", o_wr_en, 0);
      step();
    end
    m_ready  = 1'b0;
    acc_seen = acc;
    for (int h = 0; h < hold; h++) begin
      s_valid = 1'($urandom_range(1));
      #1;
      check_eq("m_valid_hold", o_mv, 1);
      check_eq("mac_en_hold", o_mac_en, 0);
      check_eq("acc_hold", acc, acc_seen);
      check_eq("x_rd_addr_hold", o_rd, j);
      step();
    end
    s_valid = 1'b0;
    check_eq("m_valid_out", o_mv, 1);
    check_eq("mac_en_out", o_mac_en, 0);
    check_eq("y", acc, golden(j));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  task automatic run_vec(input bit toggle, input bit ramp, input int first_hold, input int max_hold);
    load_vec(toggle, ramp);
    for (int j = 0; j <= cn - cm; j++) begin
      compute_out(j, (j == 0) ? first_hold : int'($urandom_range(max_hold)));
    end
    #1;
    check_eq("s_ready_reload", o_sr, 1);
    check_eq("m_valid_reload", o_mv, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check_eq("rst_s_ready", o_sr, 1);
    check_eq("rst_m_valid", o_mv, 0);
    check_eq("rst_mac_en", o_mac_en, 0);
    check_eq("rst_mac_first", o_first, 0);
    check_eq("rst_wr_addr", o_wr_addr, 0);
    check_eq("rst_rd_addr", o_rd, 0);
    check_eq("rst_f_addr", o_f, 0);
    reset = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    sel     = 1'b0;
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = 0;
    acc     = 0;
    x_q     = 0;
    f_q     = 0;
    for (int i = 0; i < 8; i++) begin
      xmem[i] = 0;
      gx[i]   = 0;
    end
    cn = 8;
    cm = 4;
    from[0] = 7;
    from[1] = 5;
    from[2] = -5;
    from[3] = -6;
    #1;
    do_reset();

    run_vec(1'b0, 1'b0, 10, 0);
    run_vec(1'b0, 1'b1, 0, 0);
    run_vec(1'b1, 1'b0, 2, 3);

    // Abort mid-window of the second output, then confirm a clean restart.
    load_vec(1'b0, 1'b0);
    compute_out(0, 0);
    step();
    step();
    do_reset();
    run_vec(1'b0, 1'b0, 0, 2);

    sel = 1'b1;
    cn = 3;
    cm = 2;
    from[0] = 3;
    from[1] = 12;
    from[2] = 0;
    from[3] = 0;
    do_reset();
    for (int v = 0; v < 4; v++) begin
      run_vec(1'(v % 2), 1'b0, v, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
